// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDRESS_WIDTH = 20;
  localparam int DEF_MAX_BURST     = 8;
  localparam int DEF_STARVE_LIMIT  = 4;

  // Arbiter sequencing: idle (CPU/EXT arbitration) or inside an EXT burst.
  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    EXT_BURST = 1'b1
  } arb_state_t;

  // Who owns the read data that memory returns next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the arbiter: CPU port, EXT burst port and memory port.
interface dmem_arbiter_if import dmem_arb_pkg::*; #(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int MAX_BURST     = DEF_MAX_BURST
) ();
  localparam int LEN_WIDTH = $clog2(MAX_BURST);

  logic                     cpu_req;
  logic                     cpu_we;
  logic                     cpu_be;
  logic [ADDRESS_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0]    cpu_wdata;
  logic                     cpu_stall;
  logic                     cpu_rvalid;
  logic [DATA_WIDTH-1:0]    cpu_rdata;

  logic                     ext_req;
  logic                     ext_we;
  logic [ADDRESS_WIDTH-1:0] ext_addr;
  logic [LEN_WIDTH-1:0]     ext_len;
  logic [DATA_WIDTH-1:0]    ext_wdata;
  logic                     ext_gnt;
  logic                     ext_beat;
  logic                     ext_rvalid;
  logic [DATA_WIDTH-1:0]    ext_rdata;
  logic                     ext_done;

  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_we;
  logic                     mem_re;
  logic                     mem_be;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  // Requesters and memory side: drives requests and memory read data.
  modport master (
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_addr, ext_len, ext_wdata,
    input  ext_gnt, ext_beat, ext_rvalid, ext_rdata, ext_done,
    input  mem_addr, mem_wdata, mem_we, mem_re, mem_be,
    output mem_rdata
  );

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_addr, ext_len, ext_wdata,
    output ext_gnt, ext_beat, ext_rvalid, ext_rdata, ext_done,
    output mem_addr, mem_wdata, mem_we, mem_re, mem_be,
    input  mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter_burst_addr_gen.sv
// Burst address generator: latches the base on grant and steps base+k
// for the remaining beats, wrapping modulo 2^ADDRESS_WIDTH.
module burst_addr_gen import dmem_arb_pkg::*; #(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int LEN_WIDTH     = $clog2(DEF_MAX_BURST)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]     start_len,
  input  logic                     advance,
  output logic [ADDRESS_WIDTH-1:0] cur_addr,
  output logic                     last,
  output logic                     active
);
  logic [ADDRESS_WIDTH-1:0] base_r;
  logic [LEN_WIDTH-1:0]     k_r;
  logic [LEN_WIDTH-1:0]     rem_r;
  logic                     active_r;

  // The first beat goes out at start_addr in the grant cycle, so the
  // counter starts at 1 and rem_r counts beats still to issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r   <= {ADDRESS_WIDTH{1'b0}};
      k_r      <= {LEN_WIDTH{1'b0}};
      rem_r    <= {LEN_WIDTH{1'b0}};
      active_r <= 1'b0;
    end else if (start) begin
      base_r   <= start_addr;
      k_r      <= LEN_WIDTH'(1);
      rem_r    <= start_len;
      active_r <= (start_len != {LEN_WIDTH{1'b0}});
    end else if (advance && active_r) begin
      k_r      <= k_r + LEN_WIDTH'(1);
      rem_r    <= rem_r - LEN_WIDTH'(1);
      active_r <= (rem_r != LEN_WIDTH'(1));
    end else begin
      k_r      <= k_r;
      rem_r    <= rem_r;
      active_r <= active_r;
    end
  end

  assign cur_addr = base_r + ADDRESS_WIDTH'(k_r);
  assign last     = active_r && (rem_r == LEN_WIDTH'(1));
  assign active   = active_r;
endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU passes through with zero latency by default,
// EXT gets non-preemptible bursts and a starvation guard.
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int MAX_BURST     = DEF_MAX_BURST,
  parameter int STARVE_LIMIT  = DEF_STARVE_LIMIT
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);
  localparam int LEN_WIDTH    = $clog2(MAX_BURST);
  localparam int STARVE_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);

  arb_state_t               state_r;
  logic [STARVE_WIDTH-1:0]  starve_cnt_r;
  logic                     burst_we_r;
  owner_t                   owner_r;
  logic                     done_r;

  logic                     starved_s;
  logic                     ext_win_s;
  logic                     cpu_issue_s;
  logic                     burst_beat_s;
  logic                     ext_beat_s;
  logic                     ext_last_s;
  logic                     ext_we_s;
  logic [ADDRESS_WIDTH-1:0] ext_beat_addr_s;
  logic [ADDRESS_WIDTH-1:0] burst_addr_s;
  logic                     gen_last_s;
  logic                     gen_active_s;
  logic [ADDRESS_WIDTH-1:0] mem_addr_s;
  logic [DATA_WIDTH-1:0]    mem_wdata_s;
  logic                     mem_we_s;
  logic                     mem_re_s;
  logic                     mem_be_s;

  burst_addr_gen #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .LEN_WIDTH     (LEN_WIDTH)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .start      (ext_win_s),
    .start_addr (bus.ext_addr),
    .start_len  (bus.ext_len),
    .advance    (burst_beat_s),
    .cur_addr   (burst_addr_s),
    .last       (gen_last_s),
    .active     (gen_active_s)
  );

  // Arbitration: who issues this cycle. Nothing issues while reset is held.
  always_comb begin
    starved_s    = (starve_cnt_r >= STARVE_MAX);
    ext_win_s    = 1'b0;
    cpu_issue_s  = 1'b0;
    burst_beat_s = 1'b0;
    if (!rst && state_r == IDLE) begin
      ext_win_s   = bus.ext_req && (!bus.cpu_req || starved_s);
      cpu_issue_s = bus.cpu_req && !ext_win_s;
    end else if (!rst && state_r == EXT_BURST) begin
      burst_beat_s = gen_active_s;
    end else begin
      burst_beat_s = 1'b0;
    end
    ext_beat_s = ext_win_s || burst_beat_s;
    if (ext_win_s) begin
      ext_beat_addr_s = bus.ext_addr;
      ext_last_s      = (bus.ext_len == {LEN_WIDTH{1'b0}});
      ext_we_s        = bus.ext_we;
    end else begin
      ext_beat_addr_s = burst_addr_s;
      ext_last_s      = gen_last_s;
      ext_we_s        = burst_we_r;
    end
  end

  // Memory port mux; EXT beats are whole-word accesses so byte mode is off.
  always_comb begin
    mem_addr_s  = {ADDRESS_WIDTH{1'b0}};
    mem_wdata_s = {DATA_WIDTH{1'b0}};
    mem_we_s    = 1'b0;
    mem_re_s    = 1'b0;
    mem_be_s    = 1'b0;
    if (cpu_issue_s) begin
      mem_addr_s  = bus.cpu_addr;
      mem_wdata_s = bus.cpu_wdata;
      mem_we_s    = bus.cpu_we;
      mem_re_s    = !bus.cpu_we;
      mem_be_s    = bus.cpu_be;
    end else if (ext_beat_s) begin
      mem_addr_s  = ext_beat_addr_s;
      mem_wdata_s = ext_we_s ? bus.ext_wdata : {DATA_WIDTH{1'b0}};
      mem_we_s    = ext_we_s;
      mem_re_s    = !ext_we_s;
      mem_be_s    = 1'b0;
    end else begin
      mem_be_s    = 1'b0;
    end
  end

  // FSM plus starvation counter, read-owner tag and last-beat flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      starve_cnt_r <= {STARVE_WIDTH{1'b0}};
      burst_we_r   <= 1'b0;
      owner_r      <= OWN_NONE;
      done_r       <= 1'b0;
    end else begin
      if (ext_win_s) begin
        starve_cnt_r <= {STARVE_WIDTH{1'b0}};
      end else if (bus.ext_req && !ext_beat_s && !starved_s) begin
        starve_cnt_r <= starve_cnt_r + STARVE_WIDTH'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end

      if (cpu_issue_s && !bus.cpu_we) begin
        owner_r <= OWN_CPU;
      end else if (ext_beat_s && !ext_we_s) begin
        owner_r <= OWN_EXT;
      end else begin
        owner_r <= OWN_NONE;
      end
      done_r <= ext_beat_s && ext_last_s;

      case (state_r)
        IDLE: begin
          if (ext_win_s) begin
            burst_we_r <= bus.ext_we;
            state_r    <= (bus.ext_len != {LEN_WIDTH{1'b0}}) ? EXT_BURST : IDLE;
          end else begin
            state_r    <= IDLE;
          end
        end
        EXT_BURST: begin
          if (!gen_active_s || (burst_beat_s && gen_last_s)) begin
            state_r <= IDLE;
          end else begin
            state_r <= EXT_BURST;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.cpu_stall  = bus.cpu_req && !cpu_issue_s && !rst;
  assign bus.ext_gnt    = ext_win_s;
  assign bus.ext_beat   = ext_beat_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_wdata  = mem_wdata_s;
  assign bus.mem_we     = mem_we_s;
  assign bus.mem_re     = mem_re_s;
  assign bus.mem_be     = mem_be_s;
  assign bus.cpu_rvalid = (owner_r == OWN_CPU);
  assign bus.cpu_rdata  = (owner_r == OWN_CPU) ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
  assign bus.ext_rvalid = (owner_r == OWN_EXT);
  assign bus.ext_rdata  = (owner_r == OWN_EXT) ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
  assign bus.ext_done   = done_r;
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer for the shared 32-bit data memory. The pipeline MEM stage (CPU port) and an external burst requester such as a loader or accelerator (EXT port) both need the memory. The CPU wins by default with zero added latency. EXT gets non-preemptible incrementing bursts, plus a starvation guard that guarantees it forward progress. The block sits between the MEM stage and `data_memory` and produces the CPU stall that feeds the hazard and PCWrite logic.

## Interface
- `DATA_WIDTH`, 32, memory word width
- `ADDRESS_WIDTH`, 20, memory address width
- `MAX_BURST`, 8, maximum EXT burst length in beats (power of two, ≥2)
- `STARVE_LIMIT`, 4, consecutive denied EXT cycles before EXT gets priority

Ports:
- `clk  in  1  single clock, rising edge`
- `rst  in  1  asynchronous, active-high reset`
- `cpu_req  in  1  CPU access request this cycle`
- `cpu_we  in  1  CPU write (else read)`
- `cpu_be  in  1  CPU byte enable, passed to memory`
- `cpu_addr  in  ADDRESS_WIDTH  CPU address`
- `cpu_wdata  in  DATA_WIDTH  CPU write data`
- `cpu_stall  out  1  CPU request not served this cycle`
- `cpu_rvalid  out  1  CPU read data valid`
- `cpu_rdata  out  DATA_WIDTH  CPU read data`
- `ext_req  in  1  EXT burst request`
- `ext_we  in  1  EXT burst is a write`
- `ext_addr  in  ADDRESS_WIDTH  EXT burst start address`
- `ext_len  in  $clog2(MAX_BURST)  beats minus one`
- `ext_wdata  in  DATA_WIDTH  EXT write data for the current beat`
- `ext_gnt  out  1  one-cycle pulse: burst accepted, first beat issued`
- `ext_beat  out  1  EXT beat issued this cycle; ext_wdata consumed`
- `ext_rvalid  out  1  EXT read data valid`
- `ext_rdata  out  DATA_WIDTH  EXT read data`
- `ext_done  out  1  one-cycle pulse: last beat completed`
- `mem_addr  out  ADDRESS_WIDTH  memory address`
- `mem_wdata  out  DATA_WIDTH  memory write data`
- `mem_we  out  1  memory write enable`
- `mem_re  out  1  memory read enable`
- `mem_be  out  1  memory byte enable`
- `mem_rdata  in  DATA_WIDTH  memory read data, valid one cycle after mem_re`

## Operation
- **FSM states:** IDLE, EXT_BURST.
- **IDLE, no starvation:** if `cpu_req` and `starve_cnt < STARVE_LIMIT`, the CPU access passes through combinationally the same cycle. `mem_*` follow the `cpu_*` inputs and `cpu_stall` = 0.
- **IDLE, EXT wins:** EXT wins if `ext_req` and (`!cpu_req` or `starve_cnt ≥ STARVE_LIMIT`).
  - First beat issued at `ext_addr`; `ext_gnt` = `ext_beat` = 1.
  - Base address latched; remaining = `ext_len`; `starve_cnt` cleared.
  - Next state is EXT_BURST if `ext_len` > 0, else IDLE.
- **EXT_BURST:** one beat per cycle at base+k (k = 1..ext_len); `ext_beat` = 1 every cycle.
  - Burst is non-preemptible, and `ext_req` is ignored until return to IDLE.
  - Returns to IDLE in the cycle the last beat issues.
- **Starvation counter:** `starve_cnt` increments, saturating, each cycle `ext_req` = 1 and no EXT beat issues. It clears on grant.
- **CPU stall:** `cpu_stall` = `cpu_req` and the CPU is not issued this cycle (EXT won in IDLE, or state is EXT_BURST).
- **Memory outputs when nothing issues:** `mem_we` = `mem_re` = `mem_be` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- **Read return:** a registered owner tag (NONE/CPU/EXT) plus a last-beat flag is captured at issue time. The next cycle, `mem_rdata` is routed to `cpu_rdata` or `ext_rdata` with the matching rvalid. The non-owner's rdata is 0.
- **ext_done:**
  - Write bursts: pulses in the cycle after the last beat issues.
  - Read bursts: coincides with the last `ext_rvalid`.
- **Address arithmetic:** beat address = base + k, modulo 2^ADDRESS_WIDTH (wraps from all-ones to 0).
- **Reset:** asynchronous; takes effect immediately, including mid-burst.
  - State goes to IDLE; counters, owner tag and all registered outputs go to 0.
  - Pending read data is dropped, with no `ext_done`.

## Timing
- **CPU latency:** 0 added cycles to issue; read data 1 cycle after issue, as with a direct memory connection.
- **EXT latency:** first beat in the `ext_gnt` cycle; N = `ext_len`+1 beats in N consecutive cycles. Read data trails issue by 1 cycle.
- **Worst-case CPU stall:** MAX_BURST cycles per EXT grant.
- **Worst-case EXT wait:** STARVE_LIMIT cycles plus any in-flight CPU issue (≤ STARVE_LIMIT+1 cycles).
- **Reset values:** every output is 0 at reset.
- **Combinational outputs:** `cpu_stall`, `ext_gnt`, `ext_beat`, `mem_*`.
- **Registered outputs:** rvalid/rdata routing and `ext_done`.

## Structure
- **Package `dmem_arb_pkg`:**
  - `arb_state_t` enum {IDLE, EXT_BURST}.
  - `owner_t` enum {OWN_NONE, OWN_CPU, OWN_EXT}.
  - Default parameter constants.
- **Sub-module `burst_addr_gen`:** holds the latched base, the beat counter and the remaining count. Outputs are the current address, the last-beat flag and the burst-active flag. The arbiter FSM and the return-path mux live in `dmem_arbiter`.

## Test plan
- **CPU only:** `cpu_req` read at 0x00010 with no EXT → mem_re=1 and cpu_stall=0 that cycle; cpu_rvalid=1 with memory content one cycle later.
- **EXT write burst:** `ext_len`=3 at 0x00100, CPU idle → ext_gnt one cycle; writes to 0x100..0x103 on 4 consecutive cycles; ext_done the cycle after the last write.
- **Contention:** cpu_req and ext_req held high, STARVE_LIMIT=4 → CPU served 4 cycles, then EXT granted; CPU stalled for `ext_len`+1 cycles, then resumes.
- **Wrap:** EXT read burst, len 1, at 0xFFFFF → beats at 0xFFFFF then 0x00000; two ext_rvalid; ext_done on the second.
- **Reset mid-burst:** rst asserted during beat 2 of an 8-beat read → all outputs 0 immediately; no ext_done; after release, a cpu_req is served the same cycle.
